// File: rtl/da_lms_ctrl_if.sv
// Purpose : sample/config/result bundle between a host and da_lms_ctrl.
// Latency : none, wires only.
// Backpressure: in_valid/in_ready on the sample channel; results and cfg writes are not flow-controlled.
// Signals : in_valid/in_ready/x_in/d_in/adapt_en (sample in), cfg_we/cfg_addr/cfg_data (tap write),
//           out_valid/y_out/e_out (result pulse), busy (controller not idle).
interface da_lms_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x_in;
  logic [11:0] d_in;
  logic        adapt_en;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [8:0]  cfg_data;
  logic        out_valid;
  logic [11:0] y_out;
  logic [11:0] e_out;
  logic        busy;

  modport slave (
    input  in_valid, x_in, d_in, adapt_en, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, y_out, e_out, busy
  );

  modport master (
    output in_valid, x_in, d_in, adapt_en, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, y_out, e_out, busy
  );
endinterface

// File: rtl/da_lms_ctrl.sv
// Purpose : sequencer for a 4-tap offset-binary DA filter core: delay line, tap weights,
//           weight-table regeneration, y/error formation and sign-sign LMS adaptation.
// Latency : result 2 cycles after acceptance; idle again after 3 (no adapt) or 15 (adapt) cycles,
//           8 cycles after a tap write.
// Backpressure: in_ready only in IDLE; out_valid is a one-cycle pulse with no backpressure.
// Ports   : clk, rst (async, active high); bus (slave modport of da_lms_ctrl_if);
//           x1..x4 delay line to the core (x1 newest); w1..w8 weight table to the core;
//           s_in/c_in carry-save result from the core.
module da_lms_ctrl #(
  parameter int STEP          = 1,
  parameter bit ADAPT_DEFAULT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  da_lms_ctrl_if.slave bus,
  output logic [7:0]   x1,
  output logic [7:0]   x2,
  output logic [7:0]   x3,
  output logic [7:0]   x4,
  output logic [9:0]   w1,
  output logic [9:0]   w2,
  output logic [9:0]   w3,
  output logic [9:0]   w4,
  output logic [9:0]   w5,
  output logic [9:0]   w6,
  output logic [9:0]   w7,
  output logic [9:0]   w8,
  input  logic [10:0]  s_in,
  input  logic [10:0]  c_in
);

  typedef enum logic [2:0] {IDLE, EVAL, ERR, UPD, TBL} state_t;

  localparam logic signed [9:0] STEP_W = 10'(STEP);

  state_t state, nstate;
  logic [2:0] cnt;

  logic signed [8:0] h [4];
  logic [9:0]        w [8];
  logic [11:0]       d_q;
  logic              adapt_q;
  logic [11:0]       y_q;
  logic [11:0]       y_out_q;
  logic [11:0]       e_out_q;
  logic              out_valid_q;

  logic accept;
  logic cfg_wr;

  // FSM next state and handshake decode; a sample beats a simultaneous cfg write.
  always_comb begin
    nstate = state;
    accept = 1'b0;
    cfg_wr = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          nstate = EVAL;
        end else if (bus.cfg_we) begin
          cfg_wr = 1'b1;
          nstate = TBL;
        end
      end
      EVAL: nstate = ERR;
      ERR:  nstate = adapt_q ? UPD : IDLE;
      UPD:  if (cnt == 3'd3) nstate = TBL;
      TBL:  if (cnt == 3'd7) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Datapath: resolve carry-save, saturated error, tap update, table entry.
  logic [11:0]       y_sum;
  logic signed [12:0] e_full;
  logic [11:0]       e_sat;
  logic signed [8:0] hk;
  logic              xk_sign;
  logic signed [9:0] upd_sum;
  logic signed [8:0] h_upd;
  logic signed [10:0] t1, t2, t3, t4, tsum;
  logic [9:0]        w_new;

  always_comb begin
    y_sum = {s_in[10], s_in} + {c_in[10], c_in};

    e_full = $signed({d_q[11], d_q}) - $signed({y_q[11], y_q});
    if (e_full > 13'sd2047)
      e_sat = 12'h7FF;
    else if (e_full < -13'sd2048)
      e_sat = 12'h800;
    else
      e_sat = e_full[11:0];

    // Tap k = cnt+1 is updated against the sign of its own delay-line sample.
    hk = h[cnt[1:0]];
    case (cnt[1:0])
      2'd0:    xk_sign = x1[7];
      2'd1:    xk_sign = x2[7];
      2'd2:    xk_sign = x3[7];
      default: xk_sign = x4[7];
    endcase
    if ((e_out_q[11] ^ xk_sign) == 1'b0)
      upd_sum = {hk[8], hk} + STEP_W;
    else
      upd_sum = {hk[8], hk} - STEP_W;
    if (e_out_q == 12'd0)
      h_upd = hk;
    else if (upd_sum > 10'sd255)
      h_upd = 9'sd255;
    else if (upd_sum < -10'sd256)
      h_upd = -9'sd256;
    else
      h_upd = upd_sum[8:0];

    // Entry index bits select the sign applied to taps 2, 3, 4 (1 = negate).
    t1 = {{2{h[0][8]}}, h[0]};
    t2 = cnt[0] ? -{{2{h[1][8]}}, h[1]} : {{2{h[1][8]}}, h[1]};
    t3 = cnt[1] ? -{{2{h[2][8]}}, h[2]} : {{2{h[2][8]}}, h[2]};
    t4 = cnt[2] ? -{{2{h[3][8]}}, h[3]} : {{2{h[3][8]}}, h[3]};
    tsum = t1 + t2 + t3 + t4;
    w_new = tsum[10:1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      x1          <= 8'd0;
      x2          <= 8'd0;
      x3          <= 8'd0;
      x4          <= 8'd0;
      d_q         <= 12'd0;
      adapt_q     <= ADAPT_DEFAULT;
      y_q         <= 12'd0;
      y_out_q     <= 12'd0;
      e_out_q     <= 12'd0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) h[i] <= 9'sd0;
      for (int i = 0; i < 8; i++) w[i] <= 10'd0;
    end else begin
      state       <= nstate;
      // Counter restarts on every state change, so UPD and TBL each count from 0.
      cnt         <= (state != nstate) ? 3'd0 : cnt + 3'd1;
      out_valid_q <= 1'b0;
      if (accept) begin
        x4      <= x3;
        x3      <= x2;
        x2      <= x1;
        x1      <= bus.x_in;
        d_q     <= bus.d_in;
        adapt_q <= bus.adapt_en;
      end
      if (cfg_wr) h[bus.cfg_addr] <= bus.cfg_data;
      if (state == EVAL) y_q <= y_sum;
      if (state == ERR) begin
        y_out_q     <= y_q;
        e_out_q     <= e_sat;
        out_valid_q <= 1'b1;
      end
      if (state == UPD) h[cnt[1:0]] <= h_upd;
      if (state == TBL) w[cnt] <= w_new;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.y_out     = y_out_q;
  assign bus.e_out     = e_out_q;

  assign w1 = w[0];
  assign w2 = w[1];
  assign w3 = w[2];
  assign w4 = w[3];
  assign w5 = w[4];
  assign w6 = w[5];
  assign w7 = w[6];
  assign w8 = w[7];

endmodule

// File: tb/tb_da_lms_ctrl.sv
// Purpose : directed self-checking bench for da_lms_ctrl.
// Latency : n/a.
// Backpressure: n/a.
module tb_da_lms_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  da_lms_ctrl_if bus();

  logic [7:0]  x1, x2, x3, x4;
  logic [9:0]  w1, w2, w3, w4, w5, w6, w7, w8;
  logic [10:0] s_in, c_in;

  da_lms_ctrl #(.STEP(1), .ADAPT_DEFAULT(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8),
    .s_in(s_in), .c_in(c_in)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tap write; returns the number of busy cycles that follow the write edge.
  task automatic cfg_write(input logic [1:0] a, input logic [8:0] d, output int nbusy);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    tick();
    bus.cfg_we = 1'b0;
    nbusy = 0;
    while (bus.busy && nbusy < 20) begin
      nbusy++;
      tick();
    end
  endtask

  // Offer one sample in IDLE; returns in cycle 0 (just after the accept edge).
  task automatic send(input logic [7:0] x, input logic [11:0] d, input logic a,
                      input logic [10:0] s, input logic [10:0] c);
    s_in         = s;
    c_in         = c;
    bus.x_in     = x;
    bus.d_in     = d;
    bus.adapt_en = a;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!bus.in_ready && n < budget) begin
      n++;
      tick();
    end
    chk("idle_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  int nb;

  initial begin
    bus.in_valid = 1'b0;
    bus.x_in     = 8'd0;
    bus.d_in     = 12'd0;
    bus.adapt_en = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = 2'd0;
    bus.cfg_data = 9'd0;
    s_in = 11'd0;
    c_in = 11'd0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y_out",     32'(bus.y_out),     32'd0);
    chk("rst_w1",        32'(w1),            32'd0);

    // Table generation: h = 8, 4, 2, -2
    cfg_write(2'd0, 9'd8, nb);      chk("cfg_busy_h1", 32'(nb), 32'd8);
    cfg_write(2'd1, 9'd4, nb);      chk("cfg_busy_h2", 32'(nb), 32'd8);
    cfg_write(2'd2, 9'd2, nb);      chk("cfg_busy_h3", 32'(nb), 32'd8);
    cfg_write(2'd3, 9'h1FE, nb);    chk("cfg_busy_h4", 32'(nb), 32'd8);
    chk("tbl_w1", 32'(w1), 32'h006);   // (8+4+2-2)/2
    chk("tbl_w2", 32'(w2), 32'h002);   // (8-4+2-2)/2
    chk("tbl_w4", 32'(w4), 32'h000);   // (8-4-2-2)/2
    chk("tbl_w5", 32'(w5), 32'h008);   // (8+4+2+2)/2
    chk("tbl_w8", 32'(w8), 32'h002);   // (8-4-2+2)/2

    // Output path, no adaptation: y = -1 + 5 = 4, e = 10 - 4 = 6
    send(8'd7, 12'd10, 1'b0, 11'h7FF, 11'd5);
    chk("op_c0_busy",  32'(bus.busy),      32'd1);
    chk("op_c0_ov",    32'(bus.out_valid), 32'd0);
    tick();
    chk("op_c1_ready", 32'(bus.in_ready),  32'd0);
    chk("op_c1_ov",    32'(bus.out_valid), 32'd0);
    tick();
    chk("op_c2_ov",    32'(bus.out_valid), 32'd1);
    chk("op_c2_y",     32'(bus.y_out),     32'h004);
    chk("op_c2_e",     32'(bus.e_out),     32'h006);
    chk("op_c2_ready", 32'(bus.in_ready),  32'd1);   // next accept on edge 3
    tick();
    chk("op_c3_ov",    32'(bus.out_valid), 32'd0);

    // Error saturation: y = -2048, d = 2047 -> e clamps to 2047
    send(8'd0, 12'h7FF, 1'b0, 11'h400, 11'h400);
    tick();
    tick();
    chk("sat_y", 32'(bus.y_out), 32'h800);
    chk("sat_e", 32'(bus.e_out), 32'h7FF);

    // Contention: sample and cfg together, sample wins
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'd0;
    bus.cfg_data = 9'd100;
    send(8'd1, 12'd0, 1'b0, 11'd0, 11'd0);
    bus.cfg_we = 1'b0;
    chk("cont_x1", 32'(x1), 32'd1);
    wait_idle(10);
    tick();
    chk("cont_busy", 32'(bus.busy), 32'd0);
    chk("cont_w1",   32'(w1),       32'h006);

    // Shifting: samples 2..5 after sample 1
    for (int i = 2; i <= 5; i++) begin
      send(8'(i), 12'd0, 1'b0, 11'd0, 11'd0);
      wait_idle(10);
    end
    chk("shift_x1", 32'(x1), 32'd5);
    chk("shift_x2", 32'(x2), 32'd4);
    chk("shift_x3", 32'(x3), 32'd3);
    chk("shift_x4", 32'(x4), 32'd2);

    // Asynchronous reset in the middle of TBL
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'd0;
    bus.cfg_data = 9'd20;
    tick();
    bus.cfg_we = 1'b0;
    tick();
    tick();
    chk("mid_w1", 32'(w1), 32'h00C);   // (20+4+2-2)/2 already written
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_busy",     32'(bus.busy),     32'd0);
    chk("arst_w1",       32'(w1),           32'd0);
    chk("arst_x1",       32'(x1),           32'd0);
    chk("arst_e_out",    32'(bus.e_out),    32'd0);
    #2 rst = 1'b0;
    repeat (10) tick();
    chk("post_w1",    32'(w1),          32'd0);
    chk("post_w8",    32'(w8),          32'd0);
    chk("post_ready", 32'(bus.in_ready), 32'd1);

    // Adaptation from h = 0: x1 = 3, x2 = -5, x3 = x4 = 0, e = 100 > 0
    send(8'hFB, 12'd0, 1'b0, 11'd0, 11'd0);
    wait_idle(10);
    send(8'd3, 12'd100, 1'b1, 11'd0, 11'd0);
    tick();
    tick();
    chk("ad_e", 32'(bus.e_out), 32'd100);
    repeat (11) tick();
    chk("ad_c13_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("ad_c14_ready", 32'(bus.in_ready), 32'd1);   // next accept on edge 15
    // h = 1, -1, 1, 1
    chk("ad_w1", 32'(w1), 32'h001);
    chk("ad_w2", 32'(w2), 32'h002);
    chk("ad_w5", 32'(w5), 32'h000);
    chk("ad_w7", 32'(w7), 32'h3FF);

    // Tap saturation at +255
    rst = 1'b1;
    #3 rst = 1'b0;
    tick();
    cfg_write(2'd3, 9'h0FF, nb);
    chk("h4_w1", 32'(w1), 32'h07F);
    send(8'd0, 12'd10, 1'b1, 11'd0, 11'd0);
    wait_idle(40);
    // h = 1, 1, 1, 255
    chk("h4sat_w1", 32'(w1), 32'h081);
    chk("h4sat_w2", 32'(w2), 32'h080);
    chk("h4sat_w8", 32'(w8), 32'h380);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
